// File: rtl/cpu_boot_pkg.sv
// Shared definitions for the IRAM boot loader: frame parser states and framing constants.
package cpu_boot_pkg;

  typedef enum logic [2:0] {
    SYNC,
    LEN_LO,
    LEN_HI,
    DATA_LO,
    DATA_HI,
    CHECK,
    DONE,
    ERR
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_BYTES = 2;
  localparam int         HDR_BYTES = 1 + LEN_BYTES;

endpackage

// File: rtl/iram_loader.sv
// Byte-stream boot loader: parses sync/length/data/checksum frames into IRAM writes
// and releases the CPU from reset only after a frame verifies.
module iram_loader
  import cpu_boot_pkg::*;
#(
  parameter int         width       = 16,
  parameter int         iaddr_width = 8,
  parameter logic [7:0] sync_byte   = SYNC_BYTE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [iaddr_width-1:0] iaddr_write,
  output logic [width-1:0]       idata_write,
  output logic                   i_write,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   error
);

  localparam int CAPACITY = 2 ** iaddr_width;

  state_e      state, state_n;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [7:0]  lo_byte;
  logic [7:0]  csum;
  logic        accept;
  logic        is_sync;
  logic        frame_start;
  logic        wr_fire;
  logic [15:0] len_full;

  assign accept   = rx_valid && rx_ready;
  assign is_sync  = (rx_data == sync_byte);
  assign len_full = {rx_data, len[7:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SYNC;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    frame_start = 1'b0;
    wr_fire     = 1'b0;
    if (accept) begin
      case (state)
        SYNC, DONE, ERR: begin
          if (is_sync) begin
            state_n     = LEN_LO;
            frame_start = 1'b1;
          end
        end
        LEN_LO: state_n = LEN_HI;
        LEN_HI: begin
          if (32'(len_full) > CAPACITY) state_n = ERR;
          else if (len_full == 16'd0)   state_n = CHECK;
          else                          state_n = DATA_LO;
        end
        DATA_LO: state_n = DATA_HI;
        DATA_HI: begin
          wr_fire = 1'b1;
          state_n = (word_idx + 16'd1 == len) ? CHECK : DATA_LO;
        end
        CHECK:   state_n = (rx_data == csum) ? DONE : ERR;
        default: state_n = SYNC;
      endcase
    end
  end

  // Frame datapath: length, byte pairing, checksum and word index need no reset
  // because every frame start reinitialises what matters.
  always_ff @(posedge clk) begin
    if (frame_start) begin
      csum     <= 8'h00;
      word_idx <= 16'd0;
    end else if (accept) begin
      case (state)
        LEN_LO:  len[7:0]  <= rx_data;
        LEN_HI:  len[15:8] <= rx_data;
        DATA_LO: begin
          lo_byte <= rx_data;
          csum    <= csum ^ rx_data;
        end
        DATA_HI: begin
          csum     <= csum ^ rx_data;
          word_idx <= word_idx + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ready    <= 1'b0;
      iaddr_write <= '0;
      idata_write <= '0;
      i_write     <= 1'b0;
    end else begin
      rx_ready <= 1'b1;
      i_write  <= wr_fire;
      if (wr_fire) begin
        idata_write <= {rx_data, lo_byte};
        iaddr_write <= word_idx[iaddr_width-1:0];
      end else if (frame_start) begin
        iaddr_write <= '0;
      end
    end
  end

  // Status is a pure function of the parser state, so a new sync in DONE
  // re-asserts cpu_reset on the following cycle.
  assign cpu_reset = (state != DONE);
  assign done      = (state == DONE);
  assign error     = (state == ERR);

endmodule
